// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the main-memory controller
package mem_pkg;

  localparam int AWIDTH_DEF = 9;
  localparam int DWIDTH_DEF = 32;

  typedef enum logic [1:0] {INIT, IDLE, BUSY} mem_state_t;

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} mem_op_t;

endpackage

// File: rtl/mem_array_sp.sv
// rtl/mem_array_sp.sv - single-port synchronous RAM with registered read data
module mem_array_sp #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] din,
  input  logic              we,
  output logic [DWIDTH-1:0] dout
);

  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  always_ff @(posedge clock) begin
    if (we)
      mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/main_mem_ctrl.sv
// rtl/main_mem_ctrl.sv - latency-modelled main memory behind the set-associative cache
import mem_pkg::*;

module main_mem_ctrl #(
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int LATENCY = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AWIDTH-1:0] addr_mem,
  input  logic [DWIDTH-1:0] data_mem_out,
  input  logic              rd_mem,
  input  logic              wr_mem,
  output logic [DWIDTH-1:0] data_mem_in,
  output logic              ready_mem,
  output logic              proto_err
);

  localparam logic [7:0]      CNT_LOAD   = 8'(LATENCY - 1);
  localparam logic [AWIDTH:0] SWEEP_LAST = {1'b0, {AWIDTH{1'b1}}};

  mem_state_t        state;
  mem_op_t           op_q;
  logic [7:0]        cnt;
  logic [AWIDTH:0]   sweep;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q;

  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_din;
  logic              ram_we;
  logic [DWIDTH-1:0] ram_dout;

  logic req;
  assign req = rd_mem | wr_mem;

  assign ready_mem = (state == IDLE) & ~rd_mem & ~wr_mem;

  // IDLE presents the incoming address so a LATENCY==1 read is issued at acceptance;
  // BUSY holds the latched address, so a longer read has dout ready at cnt==0.
  always_comb begin
    ram_addr = addr_q;
    ram_din  = data_q;
    ram_we   = 1'b0;
    unique case (state)
      INIT: begin
        ram_addr = sweep[AWIDTH-1:0];
        ram_din  = '0;
        ram_we   = 1'b1;
      end
      IDLE:    ram_addr = addr_mem;
      BUSY:    ram_we   = (op_q == OP_WR) && (cnt == 8'd0);
      default: ;
    endcase
  end

  mem_array_sp #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) u_array (
    .clock (clock),
    .addr  (ram_addr),
    .din   (ram_din),
    .we    (ram_we),
    .dout  (ram_dout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= INIT;
      op_q        <= OP_RD;
      cnt         <= '0;
      sweep       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      data_mem_in <= '0;
      proto_err   <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          if (req)
            proto_err <= 1'b1;
          if (sweep == SWEEP_LAST)
            state <= IDLE;
          else
            sweep <= sweep + (AWIDTH+1)'(1);
        end
        IDLE: begin
          if (req) begin
            addr_q <= addr_mem;
            data_q <= data_mem_out;
            op_q   <= wr_mem ? OP_WR : OP_RD;
            cnt    <= CNT_LOAD;
            state  <= BUSY;
            // A read+write collision resolves as the write.
            if (rd_mem & wr_mem)
              proto_err <= 1'b1;
          end
        end
        BUSY: begin
          if (req)
            proto_err <= 1'b1;
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            if (op_q == OP_RD)
              data_mem_in <= ram_dout;
            state <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/main_mem_ctrl.md
# main_mem_ctrl

Main-memory controller and backing store directly downstream of the 2-way set-associative cache. It accepts the cache's single-cycle `rd_mem`/`wr_mem` requests on `addr_mem`, models a fixed access latency with a countdown, and returns read data on a held register. It holds `ready_mem` low while initialising or busy. The handshake is shaped so that the cache's READMM/UPDATEMM → WAITFORMM → UPDATECACHE sequence never samples a stale `ready_mem`.

## Interface
- `AWIDTH`, 9: address width; memory depth is 2^AWIDTH words.
- `DWIDTH`, 32: word width.
- `LATENCY`, 4: busy cycles per access after acceptance; legal range 1..255.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `addr_mem` in AWIDTH: word address from the cache.
- `data_mem_out` in DWIDTH: write data from the cache; valid with `wr_mem`.
- `rd_mem` in 1: read request pulse.
- `wr_mem` in 1: write request pulse.
- `data_mem_in` out DWIDTH: registered read data to the cache.
- `ready_mem` out 1: controller idle and able to accept a request.
- `proto_err` out 1: sticky protocol-violation flag.

## Operation
- States: INIT, IDLE, BUSY.
- INIT:
  - Entered on reset.
  - Sweeps address 0..2^AWIDTH-1, writing zero, one word per cycle.
  - Moves to IDLE on the edge that writes the last word.
- `ready_mem = (state==IDLE) & ~rd_mem & ~wr_mem`.
  - This is combinational, so `ready_mem` drops in the same cycle a request is presented.
  - It is the only combinational output.
- Acceptance is at the rising edge when state==IDLE and (`rd_mem` | `wr_mem`). At that edge:
  - Latch the address, the write data and the op.
  - Load `cnt <= LATENCY-1`.
  - Go to BUSY.
- Simultaneous `rd_mem` & `wr_mem` in IDLE: accept as a write only and set `proto_err`.
- BUSY:
  - If `cnt != 0`: decrement.
  - If `cnt == 0`: perform the op and go to IDLE.
    - Read: `data_mem_in <= mem[addr]`.
    - Write: `mem[addr] <= data`, and `data_mem_in` is unchanged.
- Requests seen in BUSY or INIT: ignored; set `proto_err`.
- `data_mem_in` holds its value until the next read completes, which covers the cache latching it one cycle after seeing `ready_mem`.
- `proto_err` clears only on reset.
- Address arithmetic: the sweep counter is AWIDTH+1 bits wide. Completion is detected when the counter reaches 2^AWIDTH-1; the counter does not wrap back to 0.

## Timing
- Reset values:
  - state = INIT.
  - `ready_mem` = 0.
  - `data_mem_in` = 0.
  - `proto_err` = 0.
  - `cnt` = 0.
  - Sweep address = 0.
- Init duration: 2^AWIDTH cycles after reset deassertion. `ready_mem` first goes high in cycle 2^AWIDTH, which is cycle 512 with default parameters.
- Per access, `ready_mem` is low for 1 + LATENCY cycles: the request cycle plus the BUSY cycles.
- Read data is valid in the first cycle `ready_mem` returns high.
- Back-to-back accesses: the next request is accepted at the first edge where `ready_mem` would be high. The minimum spacing between accepted requests is LATENCY+1 cycles.
- Read-after-write to the same address returns the new data; the write completes before IDLE is re-entered.
- Reset asserted mid-access:
  - The access is aborted and a pending write is dropped.
  - Outputs take their reset values immediately.
  - INIT reruns, clearing memory.

## Structure
- Package `mem_pkg` holds:
  - `typedef enum {INIT, IDLE, BUSY} mem_state_t`.
  - Default `AWIDTH`/`DWIDTH`.
  - Op encoding (`OP_RD`, `OP_WR`).
- Sub-module `mem_array_sp`: single-port synchronous RAM with `clock`, `addr`, `din`, `we` and registered `dout`.
  - The INIT sweep and BUSY writes share its port through a mux.
  - The read op issues the RAM read in the `cnt==1` cycle so that registered `dout` lands at completion.
  - When LATENCY==1, the RAM read is issued at acceptance instead.

## Test plan
- Reset init:
  - Deassert `reset`.
  - Expect `ready_mem`=0 for 512 cycles, then 1.
  - Read 0x000 and 0x1FF; expect 0x00000000 for both.
- Write then read (LATENCY=4):
  - `wr_mem` to 0x0A5 with 0xDEADBEEF, then `rd_mem` 0x0A5.
  - Expect `ready_mem` low for 5 cycles per access.
  - Expect `data_mem_in`=0xDEADBEEF in the first ready cycle.
  - Expect the data held until the next read.
- Cache-style sequence:
  - Assert `rd_mem` for 1 cycle and check `ready_mem`=0 in that same cycle.
  - Hold `ready_mem` low for LATENCY further cycles.
  - On return, read data is stable for at least 2 cycles.
- Protocol errors:
  - `rd_mem`&`wr_mem` together at 0x010 with 0x12345678 → treated as a write: reading 0x010 returns 0x12345678, and `proto_err`=1.
  - `rd_mem` pulsed during BUSY → request ignored and `proto_err` stays 1.
- Reset mid-write:
  - Assert `reset` in BUSY of a write of 0xCAFEF00D to 0x033.
  - After init, reading 0x033 returns 0x00000000 and `proto_err`=0.
- LATENCY=1 build:
  - Run back-to-back reads of 0x001 then 0x002, previously written with 0x11 and 0x22.
  - Expect accepts spaced exactly 2 cycles apart with correct data.
